// File: rtl/serial_compare_scheduler.sv
// Round-robin scheduler that shares one MSB-first bit-serial magnitude comparator between two requesters.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN ends the shift phase on the first differing bit.
module serial_compare_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic             res_less,
    output logic             res_eq,
    output logic             res_greater,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic             rr_ptr;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             eq_f;
    logic             less_f;
    logic [CW-1:0]    cnt;
    logic             id_r;

    logic grant;
    logic grant_valid;
    logic accept;
    logic eq_n;
    logic less_n;

    // Round-robin pointer only breaks ties; a lone requester always wins.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant       = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
    end

    assign req0_ready = (state == IDLE) & grant_valid & ~grant;
    assign req1_ready = (state == IDLE) & grant_valid & grant;
    assign accept     = req0_ready | req1_ready;

    assign eq_n   = eq_f & (sh_a[WIDTH-1] == sh_b[WIDTH-1]);
    assign less_n = less_f | (eq_f & ~sh_a[WIDTH-1] & sh_b[WIDTH-1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
            sh_a   <= '0;
            sh_b   <= '0;
            eq_f   <= 1'b1;
            less_f <= 1'b0;
            cnt    <= '0;
            id_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh_a   <= grant ? req1_a : req0_a;
                        sh_b   <= grant ? req1_b : req0_b;
                        eq_f   <= 1'b1;
                        less_f <= 1'b0;
                        cnt    <= CW'(WIDTH - 1);
                        id_r   <= grant;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    eq_f   <= eq_n;
                    less_f <= less_n;
                    sh_a   <= {sh_a[WIDTH-2:0], 1'b0};
                    sh_b   <= {sh_b[WIDTH-2:0], 1'b0};
                    cnt    <= cnt - 1'b1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                    if (cnt == '0 || !eq_n) begin
                        state <= DONE;
                    end
`else
                    if (cnt == '0) begin
                        state <= DONE;
                    end
`endif
                end
                DONE: begin
                    if (res_ready) begin
                        state  <= IDLE;
                        rr_ptr <= ~id_r;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result fields are forced to zero outside DONE so the consumer never sees stale flags.
    assign res_valid   = (state == DONE);
    assign res_id      = res_valid & id_r;
    assign res_less    = res_valid & less_f;
    assign res_eq      = res_valid & eq_f;
    assign res_greater = res_valid & ~eq_f & ~less_f;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Randomized self-checking bench for serial_compare_scheduler with a transaction-level reference model.
// Directed cases pin latency, flags, arbitration order, back-pressure and mid-operation reset.
module tb_serial_compare_scheduler;

    localparam int W = 8;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam int LAT_64_62 = 6;
    localparam int LAT_12_80 = 1;
    localparam int LAT_10_20 = 3;
    localparam int LAT_80_00 = 1;
`else
    localparam int LAT_64_62 = 8;
    localparam int LAT_12_80 = 8;
    localparam int LAT_10_20 = 8;
    localparam int LAT_80_00 = 8;
`endif
    localparam int LAT_EQUAL = 8;
    localparam int LAT_01_00 = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         req1_ready;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic         res_id;
    logic         res_less;
    logic         res_eq;
    logic         res_greater;
    logic         busy;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    serial_compare_scheduler #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_less(res_less), .res_eq(res_eq), .res_greater(res_greater), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation occupies the comparator for a fixed number of cycles, then holds its result.
    bit  m_working = 1'b0;
    bit  m_done = 1'b0;
    int  m_left = 0;
    bit  m_rr = 1'b0;
    bit  m_id = 1'b0;
    bit  m_less = 1'b0;
    bit  m_eq = 1'b0;
    bit  m_gt = 1'b0;

    function automatic int model_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int i = 0; i < W; i++) begin
            if (a[W-1-i] != b[W-1-i]) return i + 1;
        end
`endif
        return W;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_working = 1'b0;
            m_done    = 1'b0;
            m_left    = 0;
            m_rr      = 1'b0;
        end else if (m_done) begin
            if (res_ready) begin
                m_done = 1'b0;
                m_rr   = ~m_id;
            end
        end else if (m_working) begin
            m_left--;
            if (m_left == 0) begin
                m_working = 1'b0;
                m_done    = 1'b1;
            end
        end else if (req0_valid || req1_valid) begin
            m_id      = (req0_valid && req1_valid) ? m_rr : req1_valid;
            m_less    = m_id ? (req1_a < req1_b) : (req0_a < req0_b);
            m_eq      = m_id ? (req1_a == req1_b) : (req0_a == req0_b);
            m_gt      = m_id ? (req1_a > req1_b) : (req0_a > req0_b);
            m_left    = m_id ? model_latency(req1_a, req1_b) : model_latency(req0_a, req0_b);
            m_working = 1'b1;
        end
    end

    // Every cycle, compare all outputs against the model in mid-cycle.
    always @(negedge clk) begin
        if (check_en) begin
            automatic bit idle = !m_working && !m_done;
            check_output("m_req0_ready", req0_ready,
                         idle && req0_valid && (!req1_valid || m_rr == 1'b0));
            check_output("m_req1_ready", req1_ready,
                         idle && req1_valid && (!req0_valid || m_rr == 1'b1));
            check_output("m_res_valid", res_valid, m_done);
            check_output("m_res_id", res_id, m_done && m_id);
            check_output("m_res_flags", {res_less, res_eq, res_greater},
                         m_done ? {m_less, m_eq, m_gt} : 3'b000);
            check_output("m_busy", busy, !idle);
        end
    end

    task automatic apply_stimulus(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                                  input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
    endtask

    task automatic run_op(input string tag,
                          input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input int hold, input bit exp_id, input logic [2:0] exp_flags,
                          input int exp_lat);
        bit found = 1'b0;
        bit got = 1'b0;
        int cyc = 0;
        apply_stimulus(v0, a0, b0, v1, a1, b1);
        res_ready = (hold == 0);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = req0_ready | req1_ready;
        end
        check_output({tag, "_accept"}, found, 1'b1);
        if (!found) return;
        check_output({tag, "_grant"}, {req1_ready, req0_ready}, exp_id ? 2'b10 : 2'b01);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = (hold > 0);
        while (cyc < 40 && !got) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            got = res_valid;
        end
        check_output({tag, "_latency"}, cyc, exp_lat);
        check_output({tag, "_id"}, res_id, exp_id);
        check_output({tag, "_flags"}, {res_less, res_eq, res_greater}, exp_flags);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_output({tag, "_hold_result"},
                         {res_valid, res_id, res_less, res_eq, res_greater},
                         {1'b1, exp_id, exp_flags});
            check_output({tag, "_hold_ready"}, {req1_ready, req0_ready}, 2'b00);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        req1_valid = 1'b0;
        @(negedge clk);
        if (hold > 0) check_output({tag, "_still_valid"}, res_valid, 1'b1);
        @(negedge clk);
        check_output({tag, "_retired"}, res_valid, 1'b0);
    endtask

    initial begin
        bit seen;
        int cyc;
        logic [3:0] ids;

        repeat (3) @(posedge clk);
        check_en = 1'b1;
        @(negedge clk);
        check_output("reset_state", {res_valid, busy, res_id, res_less, res_eq, res_greater}, 6'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        run_op("gt_64_62", 1, 8'h64, 8'h62, 0, 8'h00, 8'h00, 0, 1'b0, 3'b001, LAT_64_62);
        run_op("eq_a5_a5", 0, 8'h00, 8'h00, 1, 8'hA5, 8'hA5, 0, 1'b1, 3'b010, LAT_EQUAL);
        run_op("lt_12_80", 0, 8'h00, 8'h00, 1, 8'h12, 8'h80, 0, 1'b1, 3'b100, LAT_12_80);
        run_op("gt_80_00", 1, 8'h80, 8'h00, 0, 8'h00, 8'h00, 0, 1'b0, 3'b001, LAT_80_00);
        run_op("gt_01_00", 1, 8'h01, 8'h00, 0, 8'h00, 8'h00, 0, 1'b0, 3'b001, LAT_01_00);
        run_op("hold_10_20", 1, 8'h10, 8'h20, 0, 8'h00, 8'h00, 5, 1'b0, 3'b100, LAT_10_20);

        // Mid-operation reset: previous op left the pointer at 1, reset must bring it back to 0.
        apply_stimulus(1, 8'h3C, 8'h3C, 0, 8'h00, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = req0_ready;
        end
        check_output("midrst_accept", seen, 1'b1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("midrst_state", {res_valid, busy}, 2'b00);
        @(posedge clk);
        #1 rst = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= res_valid;
        end
        check_output("midrst_no_result", seen, 1'b0);
        run_op("midrst_rr", 1, 8'h01, 8'h02, 1, 8'h03, 8'h03, 0, 1'b0, 3'b100, 7 - (W - LAT_EQUAL) + ((LAT_12_80 == 8) ? 1 : 0));

        // Both requesters always valid after reset: grants alternate 0,1,0,1.
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        apply_stimulus(1, 8'h01, 8'h02, 1, 8'h03, 8'h03);
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            cyc = 0;
            while (cyc < 30 && !seen) begin
                @(negedge clk);
                cyc++;
                seen = res_valid;
            end
            check_output("alt_result_seen", seen, 1'b1);
            ids[k] = res_id;
            check_output("alt_flags", {res_less, res_eq, res_greater}, (k % 2 == 0) ? 3'b100 : 3'b010);
            @(negedge clk);
        end
        check_output("alt_order", ids, 4'b1010);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (12) @(posedge clk);

        // Random traffic, back-pressure and occasional resets, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = W'($urandom);
            req0_b = ($urandom_range(0, 3) == 0) ? req0_a : W'($urandom);
            req1_a = W'($urandom);
            req1_b = ($urandom_range(0, 3) == 0) ? req1_a : W'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_output("final_idle", {res_valid, busy}, 2'b00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_compare_scheduler.md
Name: serial_compare_scheduler

Overview:
- Shares one MSB-first serial magnitude-comparison datapath between two parallel requesters.
- Round-robin arbitration picks a requester, latches its operand pair, and shifts it MSB-first through internal eq/less flag logic.
- Returns the less/eq/greater result with the requester ID on a valid/ready result port.
- Sits between parallel producers and the bit-serial compare resource, and sequences that resource.

Parameters:
- WIDTH, 8, operand width in bits (>= 2)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- req0_valid  input  1  requester 0 has an operand pair
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req0_ready  output  1  requester 0 pair accepted this cycle
- req1_valid  input  1  requester 1 has an operand pair
- req1_a  input  WIDTH  requester 1 operand A
- req1_b  input  WIDTH  requester 1 operand B
- req1_ready  output  1  requester 1 pair accepted this cycle
- res_valid  output  1  result available
- res_ready  input  1  consumer takes the result
- res_id  output  1  requester that owns the result
- res_less  output  1  A < B
- res_eq  output  1  A == B
- res_greater  output  1  A > B
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rr_ptr=0, res_valid=0, res_id=0, busy=0.
  - All result flags read 0; internal eq flag=1, less flag=0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - grant = requester with valid; if both are valid, grant = rr_ptr.
  - reqN_ready = (state==IDLE) & (grant==N). This is combinational, at most one ready high per cycle, and never high outside IDLE.
  - On an accept edge: latch a/b into shift registers; eq=1, less=0; bit counter=WIDTH-1; record id; go to SHIFT.
- SHIFT (one bit per cycle, MSB first):
  - eq_n = eq & (a_msb == b_msb).
  - less_n = less | (eq & ~a_msb & b_msb).
  - Shift both registers left and decrement the counter.
  - After the counter-0 bit is consumed, go to DONE.
- DONE:
  - res_valid=1.
  - res_less = less; res_eq = eq; res_greater = ~eq & ~less. Exactly one flag is high.
  - res_id, flags and res_valid stay stable until res_ready=1.
  - On the res_valid & res_ready edge: go to IDLE and set rr_ptr = ~res_id.
- Result flags and res_id are 0 whenever res_valid=0.
- Latency: with the accept at edge E0, res_valid is high in the cycle after edge E0+WIDTH.
- Minimum period is WIDTH+2 cycles per operation (the IDLE cycle is mandatory; no accept in the same cycle as result retire).
- Request inputs may change freely while not accepted; only the accept-edge values are used.
- reqN_valid dropping before accept is legal; no grant is issued.
- res_ready held high continuously: result retires in its first DONE cycle.
- Reset asserted mid-SHIFT or mid-DONE: immediate return to reset values; no result is emitted for that operation.

Optional Feature:
- Macro SERIAL_CMP_EARLY_EXIT_EN.
- Defined: in SHIFT, if eq_n==0 on any edge, go directly to DONE on that edge. Result flags follow the same rules. Latency = index of first differing bit from MSB + 1 cycles; equal operands still take WIDTH.
- Undefined: always exactly WIDTH SHIFT cycles, regardless of operand values.

Test Plan:
- WIDTH=8, req0 a=0x64 b=0x62, res_ready=1 → req0_ready for 1 cycle; res_valid 8 cycles after accept; id=0, less/eq/greater=0/0/1.
- req1 a=0xA5 b=0xA5 → id=1, flags 0/1/0; req1 a=0x12 b=0x80 → flags 1/0/0.
- Both valid after reset (req0 0x01/0x02, req1 0x03/0x03) → req0 served first (id=0, 1/0/0), then req1 (id=1, 0/1/0). Repeat with both always valid → grants alternate 0,1,0,1.
- res_ready=0 for 5 cycles in DONE → res_valid, res_id and flags stable; req0_ready and req1_ready stay 0; result retires on the first res_ready=1 edge.
- rst pulsed low 3 cycles after an accept → res_valid=0, busy=0, rr_ptr=0; no result emitted; next request processed normally.
- With SERIAL_CMP_EARLY_EXIT_EN: a=0x80 b=0x00 → res_valid 1 cycle after accept, greater=1; a=0x01 b=0x00 → 8 cycles. Without the macro, both take 8 cycles.
